// File: rtl/array_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : array_mult_pkg
// Purpose  : Shared widths, pipeline split point and product type.
// Revision : 1.0 - initial release
// ============================================================================
package array_mult_pkg;

  localparam int MULT_W         = 16;
  localparam int PROD_W         = 2 * MULT_W;
  localparam int PIPE_SPLIT_ROW = 8;

  typedef logic [PROD_W-1:0] prod_t;

endpackage
`default_nettype wire

// File: rtl/array_mult_fa.sv
`default_nettype none
// ============================================================================
// Module   : array_mult_fa
// Purpose  : 1-bit full adder cell; a half adder is this cell with cin = 0.
// Revision : 1.0 - initial release
// ============================================================================
module array_mult_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : array_multiplier
// Purpose  : Unsigned WIDTHxWIDTH carry-save array multiplier, registered P.
//            ARRAY_MULT_PIPE_EN adds a register stage after adder row
//            PIPE_SPLIT_ROW (latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
module array_multiplier
  import array_mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               out_valid
);

  logic [WIDTH-1:0]   lo_bits;
  logic [WIDTH-1:0]   hi_bits;
  logic [WIDTH-1:0]   fin_a;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               out_valid_q, out_valid_d;
  logic               carry_unused;

`ifdef ARRAY_MULT_PIPE_EN
  logic [WIDTH-2:0]        stg_s_q, stg_s_d;
  logic [WIDTH-1:0]        stg_c_q, stg_c_d;
  logic [PIPE_SPLIT_ROW:0] stg_lo_q, stg_lo_d;
  logic                    stg_valid_q, stg_valid_d;
`endif

  // Row i adds pp[i] to the previous row's sums (shifted down one) and carries;
  // bit 0 of each row's sum is product bit i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [WIDTH-1:0] pp, s, c;

    assign pp = A & {WIDTH{B[i]}};

    if (i == 0) begin : g_first
      assign s = pp;
      assign c = '0;
    end else begin : g_add
      logic [WIDTH-1:0] s_in, c_in, pp_in;
`ifdef ARRAY_MULT_PIPE_EN
      if (i > PIPE_SPLIT_ROW) begin : g_pp_reg
        logic [WIDTH-1:0] pp_q, pp_d;
        always_comb pp_d = pp;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) pp_q <= '0;
          else        pp_q <= pp_d;
        end
        assign pp_in = pp_q;
      end else begin : g_pp_dir
        assign pp_in = pp;
      end
      if (i == PIPE_SPLIT_ROW + 1) begin : g_in_stage
        assign s_in = {1'b0, stg_s_q};
        assign c_in = stg_c_q;
      end else begin : g_in_row
        assign s_in = {1'b0, g_row[i-1].s[WIDTH-1:1]};
        assign c_in = g_row[i-1].c;
      end
`else
      assign pp_in = pp;
      assign s_in  = {1'b0, g_row[i-1].s[WIDTH-1:1]};
      assign c_in  = g_row[i-1].c;
`endif
      for (genvar j = 0; j < WIDTH; j++) begin : g_cell
        array_mult_fa u_fa (
          .a    (pp_in[j]),
          .b    (s_in[j]),
          .cin  (c_in[j]),
          .s    (s[j]),
          .cout (c[j])
        );
      end
    end

    assign lo_bits[i] = s[0];
  end

  // Final ripple row resolves the last row's sums and carries into P[2W-1:W];
  // its carry-out is always 0 because the product fits in 2*WIDTH bits.
  assign fin_a = {1'b0, g_row[WIDTH-1].s[WIDTH-1:1]};

  for (genvar j = 0; j < WIDTH; j++) begin : g_fin
    logic ci, co;
    if (j == 0) begin : g_ci_zero
      assign ci = 1'b0;
    end else begin : g_ci_chain
      assign ci = g_fin[j-1].co;
    end
    array_mult_fa u_fa (
      .a    (fin_a[j]),
      .b    (g_row[WIDTH-1].c[j]),
      .cin  (ci),
      .s    (hi_bits[j]),
      .cout (co)
    );
  end

  assign carry_unused = g_fin[WIDTH-1].co;

`ifdef ARRAY_MULT_PIPE_EN
  always_comb begin
    stg_valid_d = in_valid;
    stg_s_d     = g_row[PIPE_SPLIT_ROW].s[WIDTH-1:1];
    stg_c_d     = g_row[PIPE_SPLIT_ROW].c;
    stg_lo_d    = lo_bits[PIPE_SPLIT_ROW:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_s_q     <= '0;
      stg_c_q     <= '0;
      stg_lo_q    <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_s_q     <= stg_s_d;
      stg_c_q     <= stg_c_d;
      stg_lo_q    <= stg_lo_d;
    end
  end
`endif

  always_comb begin
    prod = {hi_bits, lo_bits};
`ifdef ARRAY_MULT_PIPE_EN
    prod[PIPE_SPLIT_ROW:0] = stg_lo_q;
`endif
  end

  always_comb begin
`ifdef ARRAY_MULT_PIPE_EN
    out_valid_d = stg_valid_q;
`else
    out_valid_d = in_valid;
`endif
    p_d = p_q;
    if (out_valid_d) p_d = prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_multiplier
// Purpose  : Self-checking bench for array_multiplier against an A*B
//            scoreboard; latency follows ARRAY_MULT_PIPE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_multiplier;
  import array_mult_pkg::*;

`ifdef ARRAY_MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N_RANDOM = 10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [MULT_W-1:0] A, B;
  prod_t             P;
  logic              out_valid;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  typedef struct {
    logic  v;
    prod_t p;
  } op_t;

  op_t   pipe_q[$];
  prod_t exp_p;
  logic  exp_v;

  array_multiplier #(.WIDTH(MULT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .P         (P),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic prod_t ref_mul(input logic [MULT_W-1:0] a, input logic [MULT_W-1:0] b);
    longint unsigned x;
    x = 64'(a) * 64'(b);
    return x[PROD_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge, check
  // both outputs against the scoreboard.
  task automatic cycle(input logic v, input logic [MULT_W-1:0] a, input logic [MULT_W-1:0] b);
    op_t it;
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
    it.v = v;
    it.p = ref_mul(a, b);
    pipe_q.push_back(it);
    exp_v = 1'b0;
    if (pipe_q.size() == LAT) begin
      it    = pipe_q.pop_front();
      exp_v = it.v;
      if (it.v) exp_p = it.p;
    end
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("P", P, exp_p);
  endtask

  task automatic issue_expect(input string tag, input logic [MULT_W-1:0] a,
                              input logic [MULT_W-1:0] b, input logic [31:0] lit);
    cycle(1'b1, a, b);
    repeat (LAT - 1) cycle(1'b0, 16'h0, 16'h0);
    chk(tag, P, lit);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  function automatic logic [MULT_W-1:0] pick_operand();
    int r;
    r = $urandom_range(15);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  initial begin
    int issued;
    logic v;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    exp_p    = '0;
    exp_v    = 1'b0;

    #2;
    chk("reset_P", P, 32'h0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_clocked_P", P, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b0, 16'h0, 16'h0);
    issue_expect("small", 16'h0050, 16'h0050, 32'h00001900);
    issue_expect("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    issue_expect("zero_a", 16'h0000, 16'hFFFF, 32'h00000000);
    issue_expect("zero_b", 16'hABCD, 16'h0000, 32'h00000000);
    repeat (2) cycle(1'b0, 16'h1234, 16'h4321);

    for (int k = 0; k < LAT + 2; k++) begin
      if (k == 0)      cycle(1'b1, 16'h1F30, 16'h1AA2);
      else if (k == 1) cycle(1'b1, 16'h2A20, 16'h1D0A);
      else             cycle(1'b0, 16'h0, 16'h0);
      if (k == LAT - 1) chk("b2b_first", P, 32'h033E9C60);
      if (k == LAT)     chk("b2b_second", P, 32'h04C74540);
    end

    // Reset asserted between clock edges with an operation in flight.
    @(negedge clk);
    in_valid = 1'b1;
    A        = 16'h1234;
    B        = 16'h5678;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_P", P, 32'h0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_P", P, 32'h0);
    chk("held_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    pipe_q.delete();
    exp_p = '0;
    repeat (LAT + 2) cycle(1'b0, 16'hFFFF, 16'hFFFF);
    issue_expect("post_rst", 16'h0003, 16'h0007, 32'h00000015);

    issued = 0;
    while (issued < N_RANDOM) begin
      v = ($urandom_range(3) != 0);
      cycle(v, pick_operand(), pick_operand());
      if (v) issued++;
    end
    repeat (LAT + 1) cycle(1'b0, 16'h0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
